// File: rtl/nibbler_pkg.sv
// Shared types and sizing for the Nibbler instruction-fetch stage.
// Fetch runs a fixed three-phase cycle: ADDR -> LATCH -> EXEC.
package nibbler_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 8;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam pc_t RST_VEC = 12'h000;

  typedef enum logic [1:0] {ADDR, LATCH, EXEC} fetch_state_t;

  // Unsigned PC_W-bit increment; the carry out is dropped so 0xFFF wraps to 0x000.
  function automatic pc_t pc_next(input pc_t p);
    return p + pc_t'(1);
  endfunction

endpackage

// File: rtl/nibbler_fetch_unit_if.sv
// Fetch-stage bus: ROM port toward program memory and instruction/jump port toward decode.
// The master side is the fetch unit; the slave side is the decode/ROM environment.
interface nibbler_fetch_unit_if;
  import nibbler_pkg::*;

  logic   stall;
  logic   jump_en;
  pc_t    jump_addr;
  instr_t rom_data;
  pc_t    rom_addr;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic   instr_valid;
  pc_t    pc;

  modport master (
    input  stall, jump_en, jump_addr, rom_data,
    output rom_addr, opcode, operand, instr_valid, pc
  );

  modport slave (
    output stall, jump_en, jump_addr, rom_data,
    input  rom_addr, opcode, operand, instr_valid, pc
  );

endinterface

// File: rtl/nibbler_pc_reg.sv
// Program counter: async reset to the reset vector, priority load > increment > hold.
module nibbler_pc_reg
  import nibbler_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic inc_i,
  input  pc_t  load_val_i,
  output pc_t  pc_o
);

  pc_t pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_val_i;
    else if (inc_i) pc_d = pc_next(pc_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= RST_VEC;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/nibbler_fetch_unit.sv
// Nibbler fetch stage: sequences ADDR/LATCH/EXEC, drives the synchronous ROM from
// the registered PC and holds the fetched instruction stable for decode in EXEC.
module nibbler_fetch_unit
  import nibbler_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  nibbler_fetch_unit_if.master bus
);

  fetch_state_t state_q, state_d;
  logic   pc_inc, pc_load, instr_en;
  pc_t    pc_q;
  instr_t instr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ADDR;
    else       state_q <= state_d;
  end

  // Stall freezes everything, including jump acceptance; decode keeps jump_en up.
  always_comb begin
    state_d  = state_q;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    instr_en = 1'b0;
    if (!bus.stall) begin
      case (state_q)
        ADDR:  state_d = LATCH;
        LATCH: begin
          instr_en = 1'b1;
          pc_inc   = 1'b1;
          state_d  = EXEC;
        end
        EXEC: begin
          pc_load = bus.jump_en;
          state_d = ADDR;
        end
        default: state_d = ADDR;
      endcase
    end
  end

  nibbler_pc_reg u_pc (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (pc_load),
    .inc_i      (pc_inc),
    .load_val_i (bus.jump_addr),
    .pc_o       (pc_q)
  );

  // The ROM keeps its data while rom_addr is stable, so a delayed capture is safe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         instr_q <= '0;
    else if (instr_en) instr_q <= bus.rom_data;
  end

  assign bus.rom_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.opcode      = instr_q[7:4];
  assign bus.operand     = instr_q[3:0];
  assign bus.instr_valid = (state_q == EXEC);

endmodule

// File: tb/tb_nibbler_fetch_unit.sv
// Bench for the Nibbler fetch stage: synchronous ROM model, scoreboard of expected
// fetches, a sequential-fetch vector table and hand-written jump/wrap/stall sequences.
module tb_nibbler_fetch_unit;
  import nibbler_pkg::*;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic [3:0]  op;
    logic [3:0]  opnd;
    logic [11:0] pc;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  opnd;
    logic [11:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  nibbler_fetch_unit_if bus();

  nibbler_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] rom [4096];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  exp_t sbq[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void push_exp(input logic [3:0] op, input logic [3:0] opnd,
                                   input logic [11:0] pc);
    exp_t e;
    e.op = op; e.opnd = opnd; e.pc = pc;
    sbq.push_back(e);
  endfunction

  // Waits for the next entry into EXEC, then pops and compares one expected fetch.
  task automatic expect_fetch(input string nm, input int budget, output int waited);
    exp_t e;
    bit   was, got;
    was = bus.instr_valid;
    got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk);
      waited++;
      if (bus.instr_valid && !was) got = 1'b1;
      was = bus.instr_valid;
    end
    if (!got) begin
      total++;
      $display("FAIL %s_timeout: no EXEC within %0d cycles", nm, budget);
      if (sbq.size() != 0) void'(sbq.pop_front());
    end else if (sbq.size() == 0) begin
      total++;
      $display("FAIL %s_sb: EXEC seen with empty scoreboard", nm);
    end else begin
      e = sbq.pop_front();
      check({nm, "_opcode"},  32'(bus.opcode),  32'(e.op));
      check({nm, "_operand"}, 32'(bus.operand), 32'(e.opnd));
      check({nm, "_pc"},      32'(bus.pc),      32'(e.pc));
    end
  endtask

  task automatic do_reset();
    sbq.delete();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t seq_tbl[6];
  int   w;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_addr = '0;
    #1;
    check("rst_pc",       32'(bus.pc),          32'h000);
    check("rst_rom_addr", 32'(bus.rom_addr),    32'h000);
    check("rst_valid",    32'(bus.instr_valid), 32'h0);
    check("rst_opcode",   32'(bus.opcode),      32'h0);
    check("rst_operand",  32'(bus.operand),     32'h0);

    // Sequential fetch table: {addr, data, opcode, operand, pc after fetch}
    seq_tbl[0] = '{12'h000, 8'h1A, 4'h1, 4'hA, 12'h001};
    seq_tbl[1] = '{12'h001, 8'h2B, 4'h2, 4'hB, 12'h002};
    seq_tbl[2] = '{12'h002, 8'h3C, 4'h3, 4'hC, 12'h003};
    seq_tbl[3] = '{12'h003, 8'hF0, 4'hF, 4'h0, 12'h004};
    seq_tbl[4] = '{12'h004, 8'h0F, 4'h0, 4'hF, 12'h005};
    seq_tbl[5] = '{12'h005, 8'hA5, 4'hA, 4'h5, 12'h006};
    for (int i = 0; i < 6; i++) rom[seq_tbl[i].addr] = seq_tbl[i].data;
    do_reset();
    for (int i = 0; i < 6; i++) push_exp(seq_tbl[i].op, seq_tbl[i].opnd, seq_tbl[i].pc);
    for (int i = 0; i < 6; i++) begin
      expect_fetch("seq", 8, w);
      if (i > 0) check("seq_gap", 32'(w), 32'd3);
    end

    // Async reset in the middle of LATCH (pc=006, opcode=A beforehand)
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_pc",       32'(bus.pc),          32'h000);
    check("arst_rom_addr", 32'(bus.rom_addr),    32'h000);
    check("arst_valid",    32'(bus.instr_valid), 32'h0);
    check("arst_opcode",   32'(bus.opcode),      32'h0);
    check("arst_operand",  32'(bus.operand),     32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Jump in EXEC of ROM[1]; a jump request outside EXEC must be ignored
    rom[12'h7F0] = 8'h55;
    rom[12'h7F1] = 8'h66;
    sbq.delete();
    push_exp(4'h1, 4'hA, 12'h001);
    expect_fetch("jmp_pre0", 8, w);
    push_exp(4'h2, 4'hB, 12'h002);
    expect_fetch("jmp_pre1", 8, w);
    bus.jump_en = 1'b1;
    bus.jump_addr = 12'h7F0;
    @(negedge clk);
    check("jmp_rom_addr", 32'(bus.rom_addr), 32'h7F0);
    bus.jump_addr = 12'h300;
    push_exp(4'h5, 4'h5, 12'h7F1);
    expect_fetch("jmp_tgt", 8, w);
    bus.jump_en = 1'b0;
    push_exp(4'h6, 4'h6, 12'h7F2);
    expect_fetch("jmp_next", 8, w);
    check("jmp_next_gap", 32'(w), 32'd3);

    // Wrap: jump to FFF, increment wraps to 000
    rom[12'hFFF] = 8'hE1;
    bus.jump_en = 1'b1;
    bus.jump_addr = 12'hFFF;
    @(negedge clk);
    bus.jump_en = 1'b0;
    check("wrap_rom_addr", 32'(bus.rom_addr), 32'hFFF);
    push_exp(4'hE, 4'h1, 12'h000);
    push_exp(4'h1, 4'hA, 12'h001);
    expect_fetch("wrap_fff", 8, w);
    expect_fetch("wrap_000", 8, w);
    check("wrap_gap", 32'(w), 32'd3);

    // Stall for 4 cycles in LATCH; capture on the first cycle after release
    rom[12'h001] = 8'h9D;
    @(negedge clk);
    @(negedge clk);
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_pc",     32'(bus.pc),          32'h001);
      check("stall_valid",  32'(bus.instr_valid), 32'h0);
      check("stall_opcode", 32'(bus.opcode),      32'h1);
    end
    bus.stall = 1'b0;
    push_exp(4'h9, 4'hD, 12'h002);
    expect_fetch("stall_cap", 4, w);
    check("stall_cap_lat", 32'(w), 32'd1);

    // Jump held under stall in EXEC: ignored until stall drops
    rom[12'h5A0] = 8'h77;
    bus.stall = 1'b1;
    bus.jump_en = 1'b1;
    bus.jump_addr = 12'h5A0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("jstall_pc",    32'(bus.pc),          32'h002);
      check("jstall_valid", 32'(bus.instr_valid), 32'h1);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    check("jstall_rom_addr", 32'(bus.rom_addr), 32'h5A0);
    bus.jump_en = 1'b0;
    push_exp(4'h7, 4'h7, 12'h5A1);
    expect_fetch("jstall_tgt", 8, w);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
